// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory port.
// Three-state FSM (IDLE/GRANT/ACK) with a wait-state timeout that reports err on the ack.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [1:0]    state_dbg
);

  // Handshake: reqN is sampled only in IDLE; once taken, the requester sees exactly one
  // ackN cycle later, with rdataN/errN valid only in that cycle. On the memory side,
  // mem_req stays high with stable mem_we/mem_addr/mem_wdata until mem_ready=1 is
  // seen in GRANT (mem_rdata sampled in that same cycle) or the wait budget runs out.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic        winner;
  logic        lat_we;
  logic [7:0]  wait_cnt;
  logic        any_req;
  logic        pick;
  logic        timeout;
  logic        done;
  logic [DW-1:0] resp_data;

  assign any_req = req0 | req1;
  // On a tie the requester that did not win last time goes next.
  assign pick    = (req0 && req1) ? ~last_grant : req1;
  assign timeout = (wait_cnt == TO_LAST);
  assign done    = (state == GRANT) && (mem_ready || timeout);
  assign resp_data = (mem_ready && !lat_we) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = GRANT;
      GRANT:   if (mem_ready || timeout) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
      winner     <= 1'b0;
      lat_we     <= 1'b0;
      wait_cnt   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
      err0       <= 1'b0;
      err1       <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        winner     <= pick;
        last_grant <= pick;
        lat_we     <= pick ? we1 : we0;
        mem_addr   <= pick ? addr1 : addr0;
        mem_wdata  <= pick ? wdata1 : wdata0;
        wait_cnt   <= '0;
      end
      if (state == GRANT) wait_cnt <= wait_cnt + 8'd1;
      // mem_ready wins over a coincident timeout, so err is simply its inverse.
      if (done) begin
        if (winner) begin
          rdata1 <= resp_data;
          err1   <= ~mem_ready;
        end else begin
          rdata0 <= resp_data;
          err0   <= ~mem_ready;
        end
      end
    end
  end

  assign mem_req   = (state == GRANT);
  assign mem_we    = (state == GRANT) && lat_we;
  assign ack0      = (state == ACK) && !winner;
  assign ack1      = (state == ACK) && winner;
  assign state_dbg = state;

endmodule
